cache_axi_refill: RTL and testbench
===================================

CACHE_AXI_REFILL -- requirements
Module: cache_axi_refill

Interface
REQ-001 SHALL have parameter CACHELINE_WD, default 512, meaning cache line width in bits (multiple of 32, at least 64).
REQ-002 SHALL have parameter BEATS, default CACHELINE_WD/32, meaning 32-bit beats per line burst.
REQ-003 SHALL have ports clk input 1, the single clock; rst input 1, asynchronous active-low reset.
REQ-004 SHALL have ports miss input 1, the cache miss request; raddr input 32, the refill address; write_back input 1, dirty victim present; waddr input 32, the victim address; cacheline_old input CACHELINE_WD, the victim data.
REQ-005 SHALL have ports refresh output 1, a one-cycle line-fill strobe; cacheline_new output CACHELINE_WD, the assembled refill line; busy output 1, high when not IDLE.
REQ-006 SHALL have read ports arvalid output 1, arready input 1, araddr output 32, arlen output 8, rvalid input 1, rready output 1, rdata input 32, rlast input 1.
REQ-007 SHALL have write ports awvalid output 1, awready input 1, awaddr output 32, awlen output 8, wvalid output 1, wready input 1, wdata output 32, wlast output 1, bvalid input 1, bready output 1.

Function
REQ-008 SHALL implement an FSM with states IDLE, AW, W, B, AR, R, and FILL.
REQ-009 SHALL sample miss only in IDLE: miss=1 with write_back=1 goes to AW, miss=1 with write_back=0 goes to AR, and anything else stays in IDLE.
REQ-010 SHALL, on leaving IDLE, capture line-aligned raddr and waddr (low log2(BEATS*4) bits zeroed) and cacheline_old, and SHALL ignore later changes to those inputs for the rest of the transaction.
REQ-011 SHALL drive arlen and awlen as constant BEATS-1.
REQ-012 SHALL, in AW, hold awvalid=1 with a stable awaddr until awready=1, then go to W.
REQ-013 SHALL, in W, hold wvalid=1 and send beat k as bits [32k+31:32k] of the captured line, starting at k=0, advancing one beat per cycle where wvalid and wready are both 1.
REQ-014 SHALL assert wlast only on beat BEATS-1, and SHALL go to B after that beat is accepted.
REQ-015 SHALL, in B, hold bready=1 and go to AR on bvalid=1, ignoring the response code.
REQ-016 SHALL, in AR, hold arvalid=1 with a stable araddr until arready=1, then go to R.
REQ-017 SHALL, in R, hold rready=1 and write each accepted rdata beat k into cacheline_new bits [32k+31:32k].
REQ-018 SHALL go from R to FILL on acceptance of beat BEATS-1, regardless of rlast; rlast is advisory only.
REQ-019 SHALL, in FILL, assert refresh for exactly one cycle with cacheline_new complete and stable, then go to IDLE.
REQ-020 SHALL hold cacheline_new stable from the FILL cycle until the next R beat is accepted.
REQ-021 SHALL use a beat counter of clog2(BEATS) bits that clears on entry to W and to R and never wraps inside a burst.
REQ-022 SHALL hold each valid high until its handshake completes, and SHALL NOT make any valid depend on the matching ready.
REQ-023 SHALL keep the victim write-back strictly before the refill read, with AR never issued before B completes.
REQ-024 SHALL NOT re-trigger on the cycle after FILL, because miss has already fallen by then.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, counter 0, and all of arvalid, awvalid, wvalid, wlast, rready, bready, refresh, and busy to 0.
REQ-026 SHALL, while rst=0, force cacheline_new, araddr, awaddr, and wdata to 0.
REQ-027 SHALL abandon any in-flight burst immediately on reset assertion.
REQ-028 SHALL leave reset synchronously to clk.

Verification
REQ-029 SHALL cover a clean refill: miss=1, write_back=0, raddr=0x1000_0044, arready=1, rdata=beat index, 16 beats -> araddr=0x1000_0040, arlen=15, one refresh pulse, cacheline_new word k equals k.
REQ-030 SHALL cover a dirty miss: write_back=1, waddr=0x2000_0080, cacheline_old word k=0xA0+k -> AW then 16 W beats 0xA0..0xAF with wlast on the 16th, then B, then AR, then refresh.
REQ-031 SHALL cover backpressure: random arready/wready/awready gaps and rvalid bubbles -> valids never drop early, data and beat order unchanged, exactly one refresh.
REQ-032 SHALL cover rlast misuse: rlast=1 on beat 3 -> the burst still completes after 16 beats and FILL occurs once.
REQ-033 SHALL cover reset mid-burst: rst=0 on W beat 7 -> all outputs 0 immediately; after release with miss=0 the block stays IDLE with busy=0.
REQ-034 SHALL cover input churn: raddr and cacheline_old change during R/W -> the bus uses the values captured in IDLE.

Source files
------------

// File: rtl/cache_axi_refill.sv
// Cache line refill engine: optional dirty-victim write-back burst followed by
// a line refill read burst over 32-bit AXI, then a one-cycle fill strobe.
module cache_axi_refill #(
    parameter int unsigned CACHELINE_WD = 512,
    parameter int unsigned BEATS        = CACHELINE_WD / 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    miss,
    input  logic [31:0]             raddr,
    input  logic                    write_back,
    input  logic [31:0]             waddr,
    input  logic [CACHELINE_WD-1:0] cacheline_old,

    output logic                    refresh,
    output logic [CACHELINE_WD-1:0] cacheline_new,
    output logic                    busy,

    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,

    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             wdata,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(BEATS * 4);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_FILL
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CACHELINE_WD-1:0] victim_line;

    // rlast is advisory and the line offset bits never reach the bus
    logic unused_inputs;
    assign unused_inputs = ^{rlast, raddr[OFF_W-1:0], waddr[OFF_W-1:0]};

    // Burst lengths are fixed by the line size
    assign arlen = 8'(BEATS - 1);
    assign awlen = 8'(BEATS - 1);

    assign cnt_inc = cnt + 1'b1;

    // Zero the byte offset inside a line
    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:OFF_W], OFF_W'(0)};
    endfunction

    // Transaction sequencer with registered bus-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            victim_line   <= '0;
            cacheline_new <= '0;
            araddr        <= '0;
            awaddr        <= '0;
            wdata         <= '0;
            arvalid       <= 1'b0;
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            wlast         <= 1'b0;
            rready        <= 1'b0;
            bready        <= 1'b0;
            refresh       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        araddr      <= line_align(raddr);
                        awaddr      <= line_align(waddr);
                        victim_line <= cacheline_old;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        if (write_back) begin
                            state   <= S_AW;
                            awvalid <= 1'b1;
                        end else begin
                            state   <= S_AR;
                            arvalid <= 1'b1;
                        end
                    end
                end

                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= victim_line[31:0];
                        wlast   <= (LAST_BEAT == '0);
                        cnt     <= '0;
                        state   <= S_W;
                    end
                end

                S_W: begin
                    if (wready) begin
                        if (cnt == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            wdata  <= '0;
                            bready <= 1'b1;
                            state  <= S_B;
                        end else begin
                            cnt   <= cnt_inc;
                            wdata <= victim_line[{cnt_inc, 5'b0} +: 32];
                            wlast <= (cnt_inc == LAST_BEAT);
                        end
                    end
                end

                S_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end

                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        state   <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid) begin
                        cacheline_new[{cnt, 5'b0} +: 32] <= rdata;
                        if (cnt == LAST_BEAT) begin
                            rready  <= 1'b0;
                            refresh <= 1'b1;
                            state   <= S_FILL;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                S_FILL: begin
                    refresh <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    arvalid <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    wlast   <= 1'b0;
                    rready  <= 1'b0;
                    bready  <= 1'b0;
                    refresh <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_refill.sv
// Bench for cache_axi_refill: randomized AXI slave with transaction logging,
// compared against line/address expectations computed from the request.
module tb_cache_axi_refill;

    localparam int unsigned LW    = 512;
    localparam int unsigned BEATS = LW / 32;

    logic          clk;
    logic          rst;
    logic          miss;
    logic [31:0]   raddr;
    logic          write_back;
    logic [31:0]   waddr;
    logic [LW-1:0] cacheline_old;
    logic          refresh;
    logic [LW-1:0] cacheline_new;
    logic          busy;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [31:0]   araddr, rdata;
    logic [7:0]    arlen, awlen;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0]   awaddr, wdata;

    cache_axi_refill #(.CACHELINE_WD(LW)) dut (
        .clk(clk), .rst(rst),
        .miss(miss), .raddr(raddr), .write_back(write_back), .waddr(waddr),
        .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new), .busy(busy),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Slave memory image for the refill and transaction logs
    logic [31:0]   rd_words [BEATS];
    logic [31:0]   aw_q[$];
    logic [31:0]   ar_q[$];
    logic [31:0]   r_q[$];
    logic [32:0]   w_q[$];
    int            b_cnt, refresh_cnt, drop_err, order_err;
    logic [LW-1:0] line_at_refresh;
    bit            bp_en, misuse, dirty;

    // Slave private state
    bit          bpend, ar_done, b_hs, r_hs;
    int          rbeat;
    bit          p_aw, p_ar, p_w;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic        p_wlast;

    function automatic logic rnd_ready();
        return ($urandom_range(0, 3) != 0);
    endfunction

    // AXI slave: drives inputs for the next rising edge, logs handshakes, checks protocol
    always @(negedge clk) begin
        if (!rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
            rvalid = 1'b0; rdata = '0; rlast = 1'b0;
            bpend = 1'b0; ar_done = 1'b0; rbeat = 0; b_hs = 1'b0; r_hs = 1'b0;
            p_aw = 1'b0; p_ar = 1'b0; p_w = 1'b0;
        end else begin
            bit aw_hs, w_hs, ar_hs;
            if (b_hs) bvalid = 1'b0;
            if (r_hs) begin rvalid = 1'b0; rlast = 1'b0; end
            awready = bp_en ? rnd_ready() : 1'b1;
            wready  = bp_en ? rnd_ready() : 1'b1;
            arready = bp_en ? rnd_ready() : 1'b1;
            if (!bvalid && bpend) bvalid = bp_en ? rnd_ready() : 1'b1;
            if (!rvalid && ar_done && rbeat < BEATS) begin
                rvalid = bp_en ? rnd_ready() : 1'b1;
                if (rvalid) begin
                    rdata = rd_words[rbeat];
                    rlast = misuse ? (rbeat == 3) : (rbeat == BEATS - 1);
                end
            end
            if (p_aw && !(awvalid === 1'b1 && awaddr === p_awaddr)) drop_err++;
            if (p_ar && !(arvalid === 1'b1 && araddr === p_araddr)) drop_err++;
            if (p_w && !(wvalid === 1'b1 && wdata === p_wdata && wlast === p_wlast)) drop_err++;
            if (dirty && arvalid && b_cnt == 0) order_err++;
            if (wvalid && aw_q.size() == 0) order_err++;

            aw_hs = awvalid && awready;
            if (aw_hs) aw_q.push_back(awaddr);
            w_hs = wvalid && wready;
            if (w_hs) begin
                w_q.push_back({wlast, wdata});
                if (w_q.size() == BEATS) bpend = 1'b1;
            end
            b_hs = bvalid && bready;
            if (b_hs) begin b_cnt++; bpend = 1'b0; end
            ar_hs = arvalid && arready;
            if (ar_hs) begin ar_q.push_back(araddr); ar_done = 1'b1; end
            r_hs = rvalid && rready;
            if (r_hs) begin r_q.push_back(rdata); rbeat++; end
            if (refresh) begin refresh_cnt++; line_at_refresh = cacheline_new; end

            p_aw = awvalid && !aw_hs; p_awaddr = awaddr;
            p_ar = arvalid && !ar_hs; p_araddr = araddr;
            p_w  = wvalid && !w_hs;   p_wdata = wdata; p_wlast = wlast;
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Expected refill line: word k of the line is memory word k
    function automatic logic [LW-1:0] expected_fill();
        logic [LW-1:0] l = '0;
        for (int k = 0; k < BEATS; k++) l = l | (LW'(rd_words[k]) << (32 * k));
        return l;
    endfunction

    function automatic logic [31:0] model_align(input logic [31:0] a);
        return a - (a % (BEATS * 4));
    endfunction

    task automatic start_txn(input bit wb, input logic [31:0] ra, input logic [31:0] wa,
                             input logic [LW-1:0] old, input bit bp, input bit mis);
        aw_q.delete(); ar_q.delete(); r_q.delete(); w_q.delete();
        b_cnt = 0; refresh_cnt = 0; drop_err = 0; order_err = 0;
        ar_done = 1'b0; rbeat = 0; bpend = 1'b0;
        dirty = wb; bp_en = bp; misuse = mis;
        @(negedge clk);
        miss = 1'b1; write_back = wb; raddr = ra; waddr = wa; cacheline_old = old;
        @(negedge clk);
        miss = 1'b0;
    endtask

    task automatic wait_done(input bit churn);
        for (int i = 0; i < 3000 && refresh_cnt == 0; i++) begin
            @(negedge clk);
            if (churn) begin
                raddr = $urandom; waddr = $urandom; cacheline_old = rand_line();
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input bit wb, input logic [31:0] ra,
                             input logic [31:0] wa, input logic [LW-1:0] old);
        check({tag, "_aw_count"}, aw_q.size(), wb ? 1 : 0);
        if (aw_q.size() > 0) check({tag, "_awaddr"}, aw_q[0], model_align(wa));
        check({tag, "_w_count"}, w_q.size(), wb ? BEATS : 0);
        for (int k = 0; k < w_q.size() && k < BEATS; k++)
            check($sformatf("%s_w_beat%0d", tag, k), w_q[k],
                  {1'(k == BEATS - 1), 32'(old >> (32 * k))});
        check({tag, "_b_count"}, b_cnt, wb ? 1 : 0);
        check({tag, "_ar_count"}, ar_q.size(), 1);
        if (ar_q.size() > 0) check({tag, "_araddr"}, ar_q[0], model_align(ra));
        check({tag, "_r_count"}, r_q.size(), BEATS);
        check({tag, "_refresh_count"}, refresh_cnt, 1);
        check({tag, "_fill_line"}, line_at_refresh, expected_fill());
        check({tag, "_line_hold"}, cacheline_new, expected_fill());
        check({tag, "_valid_hold"}, drop_err, 0);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_idle"}, {arvalid, awvalid, wvalid, rready, bready, refresh, busy}, 0);
    endtask

    initial begin
        logic [31:0]   ra, wa;
        logic [LW-1:0] old;
        bit            wb;

        rst = 1'b0; miss = 1'b0; write_back = 1'b0; raddr = '0; waddr = '0;
        cacheline_old = '0; bp_en = 1'b0; misuse = 1'b0; dirty = 1'b0;
        b_cnt = 0; refresh_cnt = 0; drop_err = 0; order_err = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {arvalid, awvalid, wvalid, wlast, rready, bready, refresh, busy}, 0);
        check("reset_data", {araddr, awaddr, wdata}, 0);
        check("reset_line", cacheline_new, 0);
        check("arlen", arlen, 15);
        check("awlen", awlen, 15);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Clean refill: rdata = beat index
        for (int k = 0; k < BEATS; k++) rd_words[k] = 32'(k);
        old = rand_line();
        start_txn(1'b0, 32'h1000_0044, 32'h0, old, 1'b0, 1'b0);
        wait_done(1'b0);
        check_txn("clean", 1'b0, 32'h1000_0044, 32'h0, old);
        check("clean_araddr_abs", araddr, 32'h1000_0040);

        // Dirty miss with victim words 0xA0+k
        for (int k = 0; k < BEATS; k++) begin
            rd_words[k] = $urandom;
            old[32*k +: 32] = 32'(32'hA0 + k);
        end
        ra = $urandom;
        start_txn(1'b1, ra, 32'h2000_0080, old, 1'b0, 1'b0);
        wait_done(1'b0);
        check_txn("dirty", 1'b1, ra, 32'h2000_0080, old);
        check("dirty_awaddr_abs", awaddr, 32'h2000_0080);

        // Random transactions under backpressure
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
            wb = 1'($urandom_range(0, 1)); ra = $urandom; wa = $urandom; old = rand_line();
            start_txn(wb, ra, wa, old, 1'b1, 1'b0);
            wait_done(1'b0);
            check_txn($sformatf("bp%0d", t), wb, ra, wa, old);
        end

        // Early rlast on beat 3
        for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
        ra = $urandom; old = rand_line();
        start_txn(1'b0, ra, 32'h0, old, 1'b0, 1'b1);
        wait_done(1'b0);
        check_txn("rlast", 1'b0, ra, 32'h0, old);

        // Input churn after capture
        for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
        ra = $urandom; wa = $urandom; old = rand_line();
        start_txn(1'b1, ra, wa, old, 1'b1, 1'b0);
        wait_done(1'b1);
        check_txn("churn", 1'b1, ra, wa, old);

        // Reset in the middle of the write burst
        for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
        start_txn(1'b1, $urandom, $urandom, rand_line(), 1'b0, 1'b0);
        for (int i = 0; i < 500 && w_q.size() < 7; i++) @(negedge clk);
        check("midrst_reached_w7", 1'(w_q.size() >= 7), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_ctrl", {arvalid, awvalid, wvalid, wlast, rready, bready, refresh, busy}, 0);
        check("midrst_data", {araddr, awaddr, wdata}, 0);
        check("midrst_line", cacheline_new, 0);
        repeat (3) @(negedge clk);
        miss = 1'b0;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_idle", {busy, awvalid, arvalid, wvalid, refresh}, 0);
        check("midrst_no_fill", refresh_cnt, 0);

        // Recovery transaction after reset
        for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
        ra = $urandom; old = rand_line();
        start_txn(1'b0, ra, 32'h0, old, 1'b1, 1'b0);
        wait_done(1'b0);
        check_txn("recover", 1'b0, ra, 32'h0, old);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
